// File: rtl/ultrasonic_echo_rx.sv
// Ultrasonic echo receiver: arms on trigger fall, times the echo pulse and
// converts its width to centimetres by counting, with a timeout abort.
// Ports:
//   clk0    in   system clock, all logic on posedge
//   rst     in   synchronous active-high reset
//   trig    in   trigger as driven to the sensor (clk0-synchronous)
//   echo    in   sensor echo pin (asynchronous)
//   dist_cm out  last result, held until the next one (all ones on timeout)
//   valid   out  one-cycle pulse when dist_cm/near/timeout update
//   near    out  last non-timeout result below NEAR_CM
//   timeout out  last result was a timeout
//   busy    out  measurement armed or in progress
module ultrasonic_echo_rx #(
    parameter int unsigned CYCLES_PER_CM  = 2900,
    parameter int unsigned TIMEOUT_CYCLES = 999000,
    parameter int unsigned NEAR_CM        = 20,
    parameter int unsigned DIST_W         = 9,
    parameter int unsigned CNT_W          = 21
) (
    input  logic              clk0,
    input  logic              rst,
    input  logic              trig,
    input  logic              echo,
    output logic [DIST_W-1:0] dist_cm,
    output logic              valid,
    output logic              near,
    output logic              timeout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]  TCNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SUB_LAST  = CNT_W'(CYCLES_PER_CM - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [DIST_W-1:0] CM_ONE    = DIST_W'(1);
    localparam logic [DIST_W-1:0] CM_MAX    = '1;

    state_e            state_q;
    logic              echo_m_q;
    logic              echo_s_q;
    logic              echo_dly_q;
    logic              trig_dly_q;
    logic [CNT_W-1:0]  tcnt_q;
    logic [CNT_W-1:0]  sub_q;
    logic [DIST_W-1:0] cm_q;
    logic [DIST_W-1:0] dist_q;
    logic              valid_q;
    logic              near_q;
    logic              timeout_q;
    logic              busy_q;

    logic              rise;
    logic              fall;
    logic              trig_rise;
    logic              trig_fall;
    logic              abort;
    logic              cm_near;
    logic [DIST_W-1:0] cm_inc;

    assign rise      = echo_s_q & ~echo_dly_q;
    assign fall      = ~echo_s_q & echo_dly_q;
    assign trig_rise = trig & ~trig_dly_q;
    assign trig_fall = ~trig & trig_dly_q;
    assign abort     = (tcnt_q == TCNT_LAST) | trig_rise;
    // Compare at 32 bits so NEAR_CM above the DIST_W range still works
    assign cm_near   = 32'(cm_q) < NEAR_CM;
    assign cm_inc    = (cm_q == CM_MAX) ? cm_q : cm_q + CM_ONE;

    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q    <= IDLE;
            echo_m_q   <= 1'b0;
            echo_s_q   <= 1'b0;
            echo_dly_q <= 1'b0;
            trig_dly_q <= 1'b0;
            tcnt_q     <= '0;
            sub_q      <= '0;
            cm_q       <= '0;
            dist_q     <= '0;
            valid_q    <= 1'b0;
            near_q     <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            echo_m_q   <= echo;
            echo_s_q   <= echo_m_q;
            echo_dly_q <= echo_s_q;
            trig_dly_q <= trig;
            valid_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (trig_fall) begin
                        tcnt_q  <= '0;
                        sub_q   <= '0;
                        cm_q    <= '0;
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM, MEAS: begin
                    tcnt_q <= tcnt_q + CNT_ONE;
                    // Timeout outranks a coincident echo fall
                    if (abort) begin
                        dist_q    <= '1;
                        near_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else if (state_q == ARM) begin
                        // Rise cycle is the first measured cycle
                        if (rise) begin
                            state_q <= MEAS;
                            if (SUB_LAST == '0) begin
                                cm_q <= cm_inc;
                            end else begin
                                sub_q <= CNT_ONE;
                            end
                        end
                    end else if (fall) begin
                        dist_q    <= cm_q;
                        near_q    <= cm_near;
                        timeout_q <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else if (sub_q == SUB_LAST) begin
                        sub_q <= '0;
                        cm_q  <= cm_inc;
                    end else begin
                        sub_q <= sub_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dist_cm = dist_q;
    assign valid   = valid_q;
    assign near    = near_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_ultrasonic_echo_rx.sv
// Randomized bench for ultrasonic_echo_rx with a behavioural result model.
// Two instances (9-bit and 4-bit distance) share one stimulus stream.
module tb_ultrasonic_echo_rx;

    localparam int CPC  = 10;
    localparam int TMO  = 1000;
    localparam int NEAR = 5;

    logic       clk0 = 1'b0;
    logic       rst  = 1'b1;
    logic       trig = 1'b0;
    logic       echo = 1'b0;
    logic [8:0] dist9;
    logic       v9, n9, t9, b9;
    logic [3:0] dist4;
    logic       v4, n4, t4, b4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int at;
        int w;
        bit to;
    } exp_t;

    exp_t q[$];
    bit   prev_v = 1'b0;

    ultrasonic_echo_rx #(
        .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TMO), .NEAR_CM(NEAR),
        .DIST_W(9), .CNT_W(21)
    ) u_dut9 (
        .clk0(clk0), .rst(rst), .trig(trig), .echo(echo),
        .dist_cm(dist9), .valid(v9), .near(n9), .timeout(t9), .busy(b9)
    );

    ultrasonic_echo_rx #(
        .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TMO), .NEAR_CM(NEAR),
        .DIST_W(4), .CNT_W(21)
    ) u_dut4 (
        .clk0(clk0), .rst(rst), .trig(trig), .echo(echo),
        .dist_cm(dist4), .valid(v4), .near(n4), .timeout(t4), .busy(b4)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Result monitor: every valid pulse must match the head of the queue
    always @(negedge clk0) begin
        exp_t e;
        int   cm, d9, d4;
        chk("valid_match", {31'd0, v4}, {31'd0, v9});
        if (v9) begin
            chk("valid_consec", {31'd0, prev_v}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_valid", q.size(), 32'd1);
            end else begin
                e = q.pop_front();
                if (e.to) begin
                    d9 = 511;
                    d4 = 15;
                end else begin
                    cm = e.w / CPC;
                    d9 = (cm > 511) ? 511 : cm;
                    d4 = (cm > 15) ? 15 : cm;
                end
                chk("valid_cycle", cyc, e.at);
                chk("dist9", {23'd0, dist9}, d9);
                chk("dist4", {28'd0, dist4}, d4);
                chk("near9", {31'd0, n9}, {31'd0, !e.to && d9 < NEAR});
                chk("near4", {31'd0, n4}, {31'd0, !e.to && d4 < NEAR});
                chk("timeout9", {31'd0, t9}, {31'd0, e.to});
                chk("timeout4", {31'd0, t4}, {31'd0, e.to});
                chk("busy_at_valid", {31'd0, b9}, 32'd0);
            end
        end
        prev_v <= v9;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk0);
            #1;
        end
    endtask

    task automatic trig_pulse(output int c);
        trig = 1'b1;
        tick(5);
        trig = 1'b0;
        c = cyc;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dist"}, {23'd0, dist9}, 32'd0);
        chk({tag, "_valid"}, {31'd0, v9}, 32'd0);
        chk({tag, "_near"}, {31'd0, n9}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, t9}, 32'd0);
        chk({tag, "_busy"}, {31'd0, b9}, 32'd0);
    endtask

    task automatic measure(input int gap, input int w);
        int c, f;
        trig_pulse(c);
        tick(gap);
        chk("busy_arm", {31'd0, b9}, 32'd1);
        echo = 1'b1;
        tick(w);
        echo = 1'b0;
        f = cyc;
        q.push_back('{at: f + 3, w: w, to: 1'b0});
        tick(10);
        chk("busy_after", {31'd0, b9}, 32'd0);
    endtask

    task automatic no_echo();
        int c;
        trig_pulse(c);
        q.push_back('{at: c + TMO + 1, w: 0, to: 1'b1});
        tick(TMO + 10);
    endtask

    // Echo in flight, next trigger rises (abort), then a new arming that
    // sees echo already high and must time out
    task automatic abort_run(input int gap, input int k);
        int c, c2, t;
        trig_pulse(c);
        tick(gap);
        echo = 1'b1;
        tick(k);
        t = cyc;
        q.push_back('{at: t + 1, w: 0, to: 1'b1});
        trig_pulse(c2);
        q.push_back('{at: c2 + TMO + 1, w: 0, to: 1'b1});
        tick(20);
        echo = 1'b0;
        tick(TMO);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            echo = ~echo;
            tick(1);
            chk_zero("in_reset");
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            echo = ~echo;
            tick(1);
            chk_zero("post_reset");
        end
        echo = 1'b0;
        tick(5);

        measure(20, 57);
        measure(20, 49);
        no_echo();

        echo = 1'b1;
        tick(5);
        trig_pulse(c);
        q.push_back('{at: c + TMO + 1, w: 0, to: 1'b1});
        tick(TMO + 10);
        echo = 1'b0;
        tick(10);
        measure(20, 57);

        measure(20, 200);
        measure(5, 9);
        measure(3, 10);
        measure(1, 1);

        trig_pulse(c);
        tick(10);
        echo = 1'b1;
        tick(30);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk_zero("mid_reset");
        tick(5);
        echo = 1'b0;
        tick(20);
        chk("mid_reset_busy_late", {31'd0, b9}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0, 1: measure($urandom_range(1, 50), $urandom_range(1, 600));
                2: no_echo();
                default: abort_run($urandom_range(1, 50), $urandom_range(1, 100));
            endcase
        end

        tick(20);
        chk("pending_expect", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
